// File: rtl/charging_policy_engine.sv
// charging_policy_engine: per-ID quota/threshold byte buckets, policy decision and a one-deep output stage
module charging_policy_engine #(
  parameter int              NUM_ID      = 4,
  parameter int              CNT_W       = 48,
  parameter logic [CNT_W-1:0] Q_TOT_INIT = CNT_W'(102400),
  parameter logic [CNT_W-1:0] Q_UL_INIT  = CNT_W'(71680),
  parameter logic [CNT_W-1:0] Q_DL_INIT  = CNT_W'(30720),
  parameter logic [CNT_W-1:0] T_TOT_INIT = CNT_W'(81920),
  parameter logic [CNT_W-1:0] T_UL_INIT  = CNT_W'(51200),
  parameter logic [CNT_W-1:0] T_DL_INIT  = CNT_W'(30720),
  parameter logic [3:0]      Q_FLAG_INIT = 4'b0011,
  parameter logic [3:0]      T_FLAG_INIT = 4'b1011
) (
  input  logic        asclk,
  input  logic        areset,
  input  logic [95:0] in_pkt_id,
  input  logic [15:0] in_pkt_len,
  input  logic        in_ul,
  input  logic        in_cnt_en,
  input  logic [13:0] in_cnt_id,
  input  logic [5:0]  in_cnt_sel,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [95:0] out_pkt_id,
  output logic [15:0] out_pkt_len,
  output logic [2:0]  out_cnt_policy,
  output logic [21:0] out_cnt_report,
  output logic        out_ul,
  output logic        out_cnt_en,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        init_done,
  output logic [31:0] bad_id_cnt
);
  localparam int IW = NUM_ID > 1 ? $clog2(NUM_ID) : 1;
  localparam logic [CNT_W-1:0] INIT_V [6] = '{Q_TOT_INIT, Q_UL_INIT, Q_DL_INIT,
                                              T_TOT_INIT, T_UL_INIT, T_DL_INIT};
  localparam logic [2:0] POL_Q = Q_FLAG_INIT[3] ? 3'd2 : 3'd1;
  localparam logic [2:0] POL_T = T_FLAG_INIT[3] ? 3'd2 : 3'd1;

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] bkt_q [NUM_ID][6];
  logic [CNT_W-1:0] nxt [6];
  logic [CNT_W-1:0] len_w;
  logic [IW-1:0]    row;
  logic             id_ok, charge, accept, q_exc, t_exc;
  logic [5:0]       act, exc;
  logic [2:0]       pol_q, pol_t, pol;

  assign len_w  = CNT_W'(in_pkt_len);
  assign id_ok  = in_cnt_id < 14'(NUM_ID);
  assign row    = in_cnt_id[IW-1:0];
  assign charge = in_cnt_en && id_ok;
  assign accept = in_vld && in_rdy;

  always_ff @(posedge asclk) begin
    if (areset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= state_q == INIT ? idx_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = (state_q == INIT && idx_q == IW'(NUM_ID - 1)) ? RUN : state_q;
  end

  always_comb begin
    init_done = state_q == RUN;
    in_rdy    = init_done && (!out_vld || out_rdy);
  end

  // Bucket order matches in_cnt_sel: b%3 selects TOT/UL/DL, b/3 selects quota/threshold
  always_comb begin
    act = '0;
    exc = '0;
    for (int b = 0; b < 6; b++) begin
      act[b] = charge && in_cnt_sel[b] && (b % 3 == 0 || (b % 3 == 1) == in_ul);
      exc[b] = act[b] && bkt_q[row][b] < len_w;
      nxt[b] = exc[b] ? '0 : bkt_q[row][b] - len_w;
    end
  end

  always_comb begin
    q_exc = |exc[2:0];
    t_exc = |exc[5:3];
    pol_q = q_exc ? POL_Q : 3'd4;
    pol_t = t_exc ? POL_T : 3'd4;
    pol   = !in_cnt_en ? 3'd4 : !id_ok ? 3'd1 : (pol_q < pol_t ? pol_q : pol_t);
  end

  always_ff @(posedge asclk) begin
    if (state_q == INIT) begin
      for (int b = 0; b < 6; b++) bkt_q[idx_q][b] <= INIT_V[b];
    end else if (accept) begin
      for (int b = 0; b < 6; b++) if (act[b]) bkt_q[row][b] <= nxt[b];
    end
  end

  always_ff @(posedge asclk) begin
    if (areset) begin
      out_vld        <= 1'b0;
      out_pkt_id     <= '0;
      out_pkt_len    <= '0;
      out_cnt_policy <= '0;
      out_cnt_report <= '0;
      out_ul         <= 1'b0;
      out_cnt_en     <= 1'b0;
      bad_id_cnt     <= '0;
    end else if (accept) begin
      out_vld        <= 1'b1;
      out_pkt_id     <= in_pkt_id;
      out_pkt_len    <= in_pkt_len;
      out_cnt_policy <= pol;
      out_cnt_report <= {t_exc, q_exc, in_cnt_sel, in_cnt_id};
      out_ul         <= in_ul;
      out_cnt_en     <= in_cnt_en;
      bad_id_cnt     <= bad_id_cnt + 32'(in_cnt_en && !id_ok);
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_charging_policy_engine.sv
// tb_charging_policy_engine: directed vector table plus hand-written stall and reset sequences
module tb_charging_policy_engine;
  logic        asclk = 1'b0;
  logic        areset = 1'b1;
  logic [95:0] in_pkt_id = '0;
  logic [15:0] in_pkt_len = '0;
  logic        in_ul = 1'b0;
  logic        in_cnt_en = 1'b0;
  logic [13:0] in_cnt_id = '0;
  logic [5:0]  in_cnt_sel = '0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [95:0] out_pkt_id;
  logic [15:0] out_pkt_len;
  logic [2:0]  out_cnt_policy;
  logic [21:0] out_cnt_report;
  logic        out_ul, out_cnt_en, out_vld;
  logic        out_rdy = 1'b1;
  logic        init_done;
  logic [31:0] bad_id_cnt;

  int n_chk = 0;
  int n_fail = 0;

  charging_policy_engine dut (
    .asclk(asclk), .areset(areset), .in_pkt_id(in_pkt_id), .in_pkt_len(in_pkt_len),
    .in_ul(in_ul), .in_cnt_en(in_cnt_en), .in_cnt_id(in_cnt_id), .in_cnt_sel(in_cnt_sel),
    .in_vld(in_vld), .in_rdy(in_rdy), .out_pkt_id(out_pkt_id), .out_pkt_len(out_pkt_len),
    .out_cnt_policy(out_cnt_policy), .out_cnt_report(out_cnt_report), .out_ul(out_ul),
    .out_cnt_en(out_cnt_en), .out_vld(out_vld), .out_rdy(out_rdy), .init_done(init_done),
    .bad_id_cnt(bad_id_cnt)
  );

  always #5 asclk = ~asclk;

  typedef struct {
    logic [13:0] id;
    logic [5:0]  sel;
    logic        ul;
    logic        en;
    logic [15:0] len;
    logic [2:0]  pol;
    logic        q;
    logic        t;
  } vec_t;

  function automatic vec_t mk(int id, int sel, int ul, int en, int len, int pol, int q, int t);
    vec_t v;
    v.id = 14'(id); v.sel = 6'(sel); v.ul = 1'(ul); v.en = 1'(en);
    v.len = 16'(len); v.pol = 3'(pol); v.q = 1'(q); v.t = 1'(t);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic drive(input vec_t v, output logic [95:0] pid);
    pid = {$urandom(), $urandom(), $urandom()};
    in_pkt_id = pid; in_pkt_len = v.len; in_ul = v.ul; in_cnt_en = v.en;
    in_cnt_id = v.id; in_cnt_sel = v.sel; in_vld = 1'b1;
  endtask

  task automatic check_out(input vec_t v, input logic [95:0] pid, input string nm);
    chk({nm, ".vld"}, out_vld, 1);
    chk({nm, ".pid"}, out_pkt_id, pid);
    chk({nm, ".len"}, out_pkt_len, v.len);
    chk({nm, ".pol"}, out_cnt_policy, v.pol);
    chk({nm, ".rep"}, out_cnt_report, {v.t, v.q, v.sel, v.id});
    chk({nm, ".ul"}, out_ul, v.ul);
    chk({nm, ".en"}, out_cnt_en, v.en);
  endtask

  task automatic xfer(input vec_t v, input string nm);
    logic [95:0] pid;
    int k;
    drive(v, pid);
    k = 0;
    while (!in_rdy && k < 100) begin
      @(posedge asclk); #1;
      k++;
    end
    chk({nm, ".rdy"}, in_rdy, 1);
    @(posedge asclk); #1;
    in_vld = 1'b0;
    check_out(v, pid, nm);
  endtask

  task automatic reset_check(input string nm);
    areset = 1'b1;
    @(posedge asclk); #1;
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk({nm, ".rdy0"}, in_rdy, 0);
      chk({nm, ".init0"}, init_done, 0);
      chk({nm, ".vld0"}, out_vld, 0);
      @(posedge asclk); #1;
    end
    chk({nm, ".rdy1"}, in_rdy, 1);
    chk({nm, ".init1"}, init_done, 1);
    chk({nm, ".vld1"}, out_vld, 0);
  endtask

  vec_t tbl [16];
  vec_t va, vb;
  logic [95:0] pa, pb;

  initial begin
    tbl[0]  = mk(0, 1, 1, 1, 1000, 4, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 500, 4, 0, 0);
    tbl[2]  = mk(5, 1, 1, 1, 500, 1, 0, 0);
    tbl[3]  = mk(4, 1, 1, 1, 500, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 65535, 4, 0, 0);
    tbl[5]  = mk(0, 1, 1, 1, 35865, 4, 0, 0);
    tbl[6]  = mk(0, 1, 1, 1, 1, 1, 1, 0);
    tbl[7]  = mk(3, 4, 0, 1, 30720, 4, 0, 0);
    tbl[8]  = mk(3, 4, 0, 1, 0, 4, 0, 0);
    tbl[9]  = mk(3, 4, 1, 1, 5, 4, 0, 0);
    tbl[10] = mk(3, 4, 0, 1, 1, 1, 1, 0);
    tbl[11] = mk(2, 36, 0, 1, 40000, 1, 1, 1);
    tbl[12] = mk(2, 36, 0, 1, 1, 1, 1, 1);
    tbl[13] = mk(2, 36, 0, 1, 0, 4, 0, 0);
    tbl[14] = mk(3, 32, 0, 1, 30721, 2, 0, 1);
    tbl[15] = mk(3, 2, 0, 1, 65535, 4, 0, 0);
    @(posedge asclk); #1;
    reset_check("rst");
    for (int i = 0; i < 16; i++) xfer(tbl[i], $sformatf("v%0d", i));
    chk("bad_id", bad_id_cnt, 2);
    for (int i = 1; i <= 52; i++)
      xfer(mk(1, 16, 1, 1, 1000, i == 52 ? 2 : 4, 0, i == 52 ? 1 : 0), $sformatf("tul%0d", i));
    xfer(mk(1, 16, 1, 1, 0, 4, 0, 0), "tul_z");
    xfer(mk(1, 16, 1, 1, 1, 2, 0, 1), "tul_e");
    va = mk(0, 1, 1, 0, 7, 4, 0, 0);
    drive(va, pa);
    @(posedge asclk); #1;
    check_out(va, pa, "stA");
    out_rdy = 1'b0;
    vb = mk(3, 8, 1, 1, 100, 4, 0, 0);
    drive(vb, pb);
    repeat (5) begin
      @(posedge asclk); #1;
      chk("st.rdy", in_rdy, 0);
      check_out(va, pa, "st.hold");
    end
    out_rdy = 1'b1;
    #1;
    chk("st.rdy1", in_rdy, 1);
    @(posedge asclk); #1;
    in_vld = 1'b0;
    check_out(vb, pb, "stB");
    xfer(mk(3, 8, 1, 1, 65535, 4, 0, 0), "tt1");
    xfer(mk(3, 8, 1, 1, 16285, 4, 0, 0), "tt2");
    xfer(mk(3, 8, 1, 1, 1, 2, 0, 1), "tt3");
    @(posedge asclk); #1;
    chk("vld_clr", out_vld, 0);
    out_rdy = 1'b0;
    drive(mk(0, 1, 1, 1, 5, 4, 0, 0), pa);
    @(posedge asclk); #1;
    in_vld = 1'b0;
    chk("pend.vld", out_vld, 1);
    reset_check("rst2");
    out_rdy = 1'b1;
    chk("bad_id_rst", bad_id_cnt, 0);
    xfer(mk(0, 1, 1, 1, 65535, 4, 0, 0), "ri1");
    xfer(mk(0, 1, 1, 1, 36865, 4, 0, 0), "ri2");
    xfer(mk(0, 1, 1, 1, 1, 1, 1, 0), "ri3");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
